// File: rtl/pipelined_adder_accum.sv
// Add/sub/accumulate unit behind a STAGES-deep registered pipeline with valid/ready and flush.
// Optional build macro SATURATE_EN clamps results instead of wrapping modulo 2^WIDTH.
module pipelined_adder_accum #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic [WIDTH-1:0] acc_out
);

  localparam logic [1:0] ModeAdd = 2'b00;
  localparam logic [1:0] ModeSub = 2'b01;
  localparam logic [1:0] ModeAcc = 2'b10;

  logic [STAGES-1:0] r_vld;
  logic              r_cry [STAGES];
  logic [WIDTH-1:0]  r_sum [STAGES];
  logic [WIDTH-1:0]  r_acc;

  logic              w_stall;
  logic              w_accept;
  logic [WIDTH:0]    w_raw;
  logic [WIDTH-1:0]  w_sum;
  logic              w_cry;

  assign w_stall  = r_vld[STAGES-1] && !out_ready;
  assign in_ready = !w_stall;
  assign w_accept = in_valid && in_ready && !flush;

  // Result is computed at accept; acc is updated at accept too, so acc beats chain without forwarding.
  always_comb begin
    w_raw = '0;
    case (mode)
      ModeAdd: w_raw = {1'b0, a} + {1'b0, b};
      ModeSub: w_raw = {1'b0, a} - {1'b0, b};
      ModeAcc: w_raw = {1'b0, r_acc} + {1'b0, a};
      default: w_raw = {1'b0, a};
    endcase
    w_cry = w_raw[WIDTH];
`ifdef SATURATE_EN
    if (w_cry) begin
      w_sum = (mode == ModeSub) ? '0 : '1;
    end else begin
      w_sum = w_raw[WIDTH-1:0];
    end
`else
    w_sum = w_raw[WIDTH-1:0];
`endif
  end

  // Stage data only loads behind a valid beat, so the output holds its last value across bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      r_acc <= '0;
      for (int i = 0; i < STAGES; i++) begin
        r_sum[i] <= '0;
        r_cry[i] <= 1'b0;
      end
    end else if (flush) begin
      r_vld <= '0;
      r_acc <= '0;
    end else if (!w_stall) begin
      r_vld <= (r_vld << 1) | STAGES'(w_accept);
      if (w_accept) begin
        r_sum[0] <= w_sum;
        r_cry[0] <= w_cry;
        if (mode[1]) begin
          r_acc <= w_sum;
        end
      end
      for (int i = 1; i < STAGES; i++) begin
        if (r_vld[i-1]) begin
          r_sum[i] <= r_sum[i-1];
          r_cry[i] <= r_cry[i-1];
        end
      end
    end
  end

  assign out_valid = r_vld[STAGES-1];
  assign sum       = r_sum[STAGES-1];
  assign carry     = r_cry[STAGES-1];
  assign acc_out   = r_acc;

endmodule

// File: tb/tb_pipelined_adder_accum.sv
// Directed bench for pipelined_adder_accum: queue-based reference model checked every cycle,
// plus literal expectations for the main scenarios and STAGES=1/4 latency instances.
module tb_pipelined_adder_accum;

  localparam int S = 2;
`ifdef SATURATE_EN
  localparam bit Sat = 1'b1;
`else
  localparam bit Sat = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic [1:0] mode = 2'b00;
  logic [7:0] a = 8'd0;
  logic [7:0] b = 8'd0;

  logic       in_ready, out_valid, carry;
  logic [7:0] sum, acc_out;
  logic       s1_in_ready, s1_out_valid, s1_carry;
  logic [7:0] s1_sum, s1_acc_out;
  logic       s4_in_ready, s4_out_valid, s4_carry;
  logic [7:0] s4_sum, s4_acc_out;

  pipelined_adder_accum #(.WIDTH(8), .STAGES(S)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .carry(carry), .acc_out(acc_out)
  );

  pipelined_adder_accum #(.WIDTH(8), .STAGES(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(s1_in_ready),
    .a(a), .b(b), .mode(mode), .out_valid(s1_out_valid), .out_ready(1'b1),
    .sum(s1_sum), .carry(s1_carry), .acc_out(s1_acc_out)
  );

  pipelined_adder_accum #(.WIDTH(8), .STAGES(4)) u_s4 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(s4_in_ready),
    .a(a), .b(b), .mode(mode), .out_valid(s4_out_valid), .out_ready(1'b1),
    .sum(s4_sum), .carry(s4_carry), .acc_out(s4_acc_out)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  task automatic chk(input string nm, input int got_v, input int exp_v);
    vectors++;
    if (got_v != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got_v, exp_v, cyc);
    end
  endtask

  // Reference model: in-flight results with their pipeline position; all move together unless stalled.
  typedef struct {
    logic [8:0] res;
    int         pos;
  } ent_t;
  ent_t       q[$];
  int         m_acc = 0;
  logic [8:0] m_last = 9'd0;

  function automatic logic [8:0] calc(input int md, input int x, input int y, input int acc);
    int r;
    bit c;
    case (md)
      0: r = x + y;
      1: r = x - y;
      2: r = acc + x;
      default: r = x;
    endcase
    c = (md == 1) ? (r < 0) : (r > 255);
    if (c && Sat) r = (md == 1) ? 0 : 255;
    return {c, 8'(r & 255)};
  endfunction

  function automatic bit m_valid();
    return q.size() > 0 && q[0].pos == S;
  endfunction

  initial begin
    logic [8:0] r;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        q.delete();
        m_acc  = 0;
        m_last = 9'd0;
      end else if (flush) begin
        q.delete();
        m_acc = 0;
      end else if (!(m_valid() && !out_ready)) begin
        if (m_valid()) void'(q.pop_front());
        foreach (q[i]) q[i].pos = q[i].pos + 1;
        if (in_valid) begin
          r = calc(int'(mode), int'(a), int'(b), m_acc);
          if (mode[1]) m_acc = int'(r[7:0]);
          q.push_back('{res: r, pos: 1});
        end
        if (m_valid()) m_last = q[0].res;
      end
    end
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Per-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      chk("out_valid", int'(out_valid), int'(m_valid()));
      chk("in_ready", int'(in_ready), int'(!(m_valid() && !out_ready)));
      chk("acc_out", int'(acc_out), m_acc);
      chk("sum", int'(sum), int'(m_last[7:0]));
      chk("carry", int'(carry), int'(m_last[8]));
    end
  end

  // Delivered results, captured just before the edge that hands them off.
  logic [8:0] got[$];
  int         gcyc[$];
  initial forever begin
    @(negedge clk);
    #4;
    if (rst_n && out_valid && out_ready) begin
      got.push_back({carry, sum});
      gcyc.push_back(cyc);
    end
  end

  function automatic int gat(input int i);
    return (i < got.size()) ? int'(got[i]) : -1;
  endfunction

  function automatic int gcy(input int i);
    return (i < gcyc.size()) ? gcyc[i] : -1000;
  endfunction

  // Present a beat and hold it until an edge accepts it; returns 2 time units after that edge.
  task automatic send(input logic [1:0] md, input logic [7:0] x, input logic [7:0] y);
    bit ok;
    in_valid = 1'b1;
    mode     = md;
    a        = x;
    b        = y;
    ok       = 1'b0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      #3;
      ok = in_ready;
    end
    if (!ok) chk("send_timeout", 0, 1);
    @(posedge clk);
    #2;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, l1, l2, l4;
    bit seen;

    #1 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_sum", int'(sum), 0);
    chk("rst_carry", int'(carry), 0);
    chk("rst_acc_out", int'(acc_out), 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    idle(1);

    // Add with carry and its latency.
    got.delete();
    gcyc.delete();
    send(2'b00, 8'd200, 8'd100);
    lat  = 0;
    seen = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (!seen && out_valid) begin
        lat  = k;
        seen = 1'b1;
      end
    end
    chk("add_latency", lat, 2);
    chk("add200_100", gat(0), 256 + (Sat ? 255 : 44));
    idle(1);

    // Subtract both directions.
    got.delete();
    send(2'b01, 8'd5, 8'd9);
    send(2'b01, 8'd9, 8'd5);
    idle(4);
    chk("sub5_9", gat(0), 256 + (Sat ? 0 : 252));
    chk("sub9_5", gat(1), 4);

    // Load then two back-to-back accumulates.
    got.delete();
    gcyc.delete();
    send(2'b11, 8'd10, 8'd0);
    send(2'b10, 8'd20, 8'd0);
    send(2'b10, 8'd30, 8'd0);
    chk("acc_after_last", int'(acc_out), 60);
    idle(4);
    chk("acc_r0", gat(0), 10);
    chk("acc_r1", gat(1), 30);
    chk("acc_r2", gat(2), 60);
    chk("acc_gap01", gcy(1) - gcy(0), 1);
    chk("acc_gap12", gcy(2) - gcy(1), 1);

    // Backpressure: stall three cycles once the first result shows.
    got.delete();
    fork
      begin
        send(2'b00, 8'd1, 8'd1);
        send(2'b00, 8'd2, 8'd2);
        send(2'b00, 8'd3, 8'd3);
        send(2'b00, 8'd4, 8'd4);
      end
      begin
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
          @(negedge clk);
          seen = out_valid;
        end
        if (!seen) chk("bp_wait_valid", 0, 1);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk("stall_in_ready", int'(in_ready), 0);
        chk("stall_sum", int'(sum), 2);
        @(negedge clk);
        chk("stall_sum_held", int'(sum), 2);
        @(posedge clk);
        #2 out_ready = 1'b1;
      end
    join
    idle(6);
    chk("bp_count", got.size(), 4);
    chk("bp_r0", gat(0), 2);
    chk("bp_r1", gat(1), 4);
    chk("bp_r2", gat(2), 6);
    chk("bp_r3", gat(3), 8);
    chk("bp_acc_kept", int'(acc_out), 60);

    // Flush with two beats in flight and a beat presented in the flush cycle.
    send(2'b00, 8'd1, 8'd1);
    send(2'b00, 8'd2, 8'd2);
    flush    = 1'b1;
    in_valid = 1'b1;
    mode     = 2'b00;
    a        = 8'd50;
    b        = 8'd50;
    @(posedge clk);
    #2;
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", int'(out_valid), 0);
    chk("flush_acc_out", int'(acc_out), 0);
    got.delete();
    idle(1);
    send(2'b10, 8'd7, 8'd0);
    idle(4);
    chk("flush_count", got.size(), 1);
    chk("flush_acc7", gat(0), 7);

    // Asynchronous reset between edges while a result is at the output.
    send(2'b00, 8'd3, 8'd4);
    send(2'b00, 8'd5, 8'd6);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", int'(out_valid), 0);
    chk("arst_sum", int'(sum), 0);
    chk("arst_acc_out", int'(acc_out), 0);
    chk("arst_s4_acc", int'(s4_acc_out), 0);
    @(posedge clk);
    #2;
    rst_n    = 1'b1;
    in_valid = 1'b1;
    mode     = 2'b00;
    a        = 8'd1;
    b        = 8'd2;
    @(posedge clk);
    #2 in_valid = 1'b0;
    l1 = 0;
    l2 = 0;
    l4 = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (l1 == 0 && s1_out_valid) l1 = k;
      if (l2 == 0 && out_valid) l2 = k;
      if (l4 == 0 && s4_out_valid) l4 = k;
    end
    chk("lat_stages1", l1, 1);
    chk("lat_stages2", l2, 2);
    chk("lat_stages4", l4, 4);
    chk("s4_sum", int'(s4_sum), 3);
    chk("s1_sum", int'(s1_sum), 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
